// File: rtl/mips_instr_encoder.sv
// Sequential MIPS instruction encoder: symbolic requests in, 32-bit words plus word address out.
// Optional macro MIPS_ENC_LUI_EN enables two-word lui/ori expansion of wide LI requests.
module mips_instr_encoder #(
    parameter int unsigned ADDR_W = 6
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              clear,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [2:0]        in_kind,
    input  logic [4:0]        in_rs,
    input  logic [4:0]        in_rt,
    input  logic [4:0]        in_rd,
    input  logic [5:0]        in_funct,
    input  logic [31:0]       in_imm,
    input  logic [25:0]       in_target,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [31:0]       out_instr,
    output logic [ADDR_W-1:0] out_addr,
    output logic              full,
    output logic              err
);

    typedef enum logic [1:0] {StIdle, StHold, StHoldHi} state_e;

    state_e            r_state, w_state_d;
    logic [31:0]       r_instr, w_instr_d;
    logic [31:0]       r_lo, w_lo_d;
    logic [ADDR_W-1:0] r_addr, w_addr_d;
    logic              r_full, w_full_d;
    logic              r_err, w_err_d;

    logic [31:0]       w_word0, w_word1;
    logic [ADDR_W-1:0] w_load_addr;
    logic              w_two, w_bad, w_drop, w_accept, w_consume, w_li_fits;

    // LI fits one addi when imm is a sign-extended 16-bit value.
    assign w_li_fits = (in_imm[31:15] == '0) || (in_imm[31:15] == '1);

    always_comb begin
        w_word0 = '0;
        w_word1 = '0;
        w_two   = 1'b0;
        w_bad   = 1'b0;
        case (in_kind)
            3'd0: w_word0 = {6'b000000, in_rs, in_rt, in_rd, 5'b00000, in_funct};
            3'd1: w_word0 = {6'b100011, in_rs, in_rt, in_imm[15:0]};
            3'd2: w_word0 = {6'b101011, in_rs, in_rt, in_imm[15:0]};
            3'd3: w_word0 = {6'b000100, in_rs, in_rt, in_imm[15:0]};
            3'd4: w_word0 = {6'b001000, in_rs, in_rt, in_imm[15:0]};
            3'd5: w_word0 = {6'b000010, in_target};
            3'd6: begin
                if (w_li_fits) begin
                    w_word0 = {6'b001000, 5'b00000, in_rt, in_imm[15:0]};
                end else begin
`ifdef MIPS_ENC_LUI_EN
                    w_word0 = {6'b001111, 5'b00000, in_rt, in_imm[31:16]};
                    w_word1 = {6'b001101, in_rt, in_rt, in_imm[15:0]};
                    w_two   = 1'b1;
`else
                    w_bad   = 1'b1;
`endif
                end
            end
            default: w_word0 = '0;
        endcase
    end

    assign out_valid = (r_state != StIdle);
    assign out_instr = r_instr;
    assign out_addr  = r_addr;
    assign full      = r_full;
    assign err       = r_err;

    assign in_ready  = !r_full && !clear &&
                       ((r_state == StIdle) || ((r_state == StHold) && out_ready));
    assign w_consume = out_valid && out_ready;
    assign w_accept  = in_valid && in_ready;

    // Accepting from HOLD consumes the held word, so the new word lands one slot later.
    assign w_load_addr = (r_state == StIdle) ? r_addr : r_addr + ADDR_W'(1);
    assign w_drop      = w_bad || (w_two && (w_load_addr == {ADDR_W{1'b1}}));

    always_comb begin
        w_state_d = r_state;
        w_instr_d = r_instr;
        w_lo_d    = r_lo;
        w_addr_d  = r_addr;
        w_full_d  = r_full;
        w_err_d   = 1'b0;
        if (clear) begin
            w_state_d = StIdle;
            w_instr_d = '0;
            w_addr_d  = '0;
            w_full_d  = 1'b0;
        end else begin
            if (w_consume) begin
                w_addr_d = r_addr + ADDR_W'(1);
                if (r_addr == {ADDR_W{1'b1}}) begin
                    w_full_d = 1'b1;
                end
                if (r_state == StHoldHi) begin
                    w_instr_d = r_lo;
                    w_state_d = StHold;
                end else begin
                    w_state_d = StIdle;
                end
            end
            if (w_accept) begin
                if (w_drop) begin
                    w_err_d = 1'b1;
                end else begin
                    w_instr_d = w_word0;
                    w_lo_d    = w_word1;
                    w_state_d = w_two ? StHoldHi : StHold;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= StIdle;
            r_instr <= '0;
            r_lo    <= '0;
            r_addr  <= '0;
            r_full  <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_state_d;
            r_instr <= w_instr_d;
            r_lo    <= w_lo_d;
            r_addr  <= w_addr_d;
            r_full  <= w_full_d;
            r_err   <= w_err_d;
        end
    end

endmodule

// File: tb/tb_mips_instr_encoder.sv
// Self-checking bench for mips_instr_encoder: directed scenarios plus randomized traffic
// against a queue-based reference model. Honors MIPS_ENC_LUI_EN when defined.
module tb_mips_instr_encoder;

    localparam int AW  = 2;
    localparam int CAP = 4;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          clear = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [2:0]    in_kind = '0;
    logic [4:0]    in_rs = '0, in_rt = '0, in_rd = '0;
    logic [5:0]    in_funct = '0;
    logic [31:0]   in_imm = '0;
    logic [25:0]   in_target = '0;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [31:0]   out_instr;
    logic [AW-1:0] out_addr;
    logic          full;
    logic          err;

    int n_total = 0;
    int n_bad   = 0;

    // Reference model state: pending words in emission order, address of the front word.
    logic [31:0] m_q[$];
    int          m_addr;
    bit          m_full;
    bit          m_err;

    always #5 clk = ~clk;

    mips_instr_encoder #(.ADDR_W(AW)) dut (
        .clk       (clk),
        .reset     (reset),
        .clear     (clear),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_kind   (in_kind),
        .in_rs     (in_rs),
        .in_rt     (in_rt),
        .in_rd     (in_rd),
        .in_funct  (in_funct),
        .in_imm    (in_imm),
        .in_target (in_target),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_instr (out_instr),
        .out_addr  (out_addr),
        .full      (full),
        .err       (err)
    );

    task automatic do_reset();
        reset = 1'b1; clear = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic drive(input logic [2:0] k, input logic [4:0] rs, input logic [4:0] rt,
                         input logic [4:0] rd, input logic [5:0] fn, input logic [31:0] imm,
                         input logic [25:0] tgt);
        in_valid = 1'b1; in_kind = k; in_rs = rs; in_rt = rt; in_rd = rd;
        in_funct = fn; in_imm = imm; in_target = tgt;
    endtask

    // Arithmetic encoding straight from the field layout; n=0 means the request is dropped.
    task automatic model_encode(output int n, output logic [31:0] w0, output logic [31:0] w1);
        int simm;
        w0 = 0; w1 = 0; n = 1;
        simm = $signed(in_imm);
        case (int'(in_kind))
            0: w0 = (32'(in_rs) << 21) + (32'(in_rt) << 16) + (32'(in_rd) << 11) + 32'(in_funct);
            1: w0 = (32'd35 << 26) + (32'(in_rs) << 21) + (32'(in_rt) << 16) + (in_imm % 65536);
            2: w0 = (32'd43 << 26) + (32'(in_rs) << 21) + (32'(in_rt) << 16) + (in_imm % 65536);
            3: w0 = (32'd4 << 26) + (32'(in_rs) << 21) + (32'(in_rt) << 16) + (in_imm % 65536);
            4: w0 = (32'd8 << 26) + (32'(in_rs) << 21) + (32'(in_rt) << 16) + (in_imm % 65536);
            5: w0 = (32'd2 << 26) + 32'(in_target);
            6: begin
                if (simm >= -32768 && simm <= 32767) begin
                    w0 = (32'd8 << 26) + (32'(in_rt) << 16) + (in_imm % 65536);
                end else begin
`ifdef MIPS_ENC_LUI_EN
                    n  = 2;
                    w0 = (32'd15 << 26) + (32'(in_rt) << 16) + (in_imm / 65536);
                    w1 = (32'd13 << 26) + (32'(in_rt) << 21) + (32'(in_rt) << 16) + (in_imm % 65536);
`else
                    n  = 0;
`endif
                end
            end
            default: w0 = 0;
        endcase
    endtask

    task automatic test_reset();
        do_reset();
        out_ready = 1'b1;
        drive(3'd0, 5'd1, 5'd2, 5'd3, 6'h20, 0, 0);
        @(posedge clk); @(negedge clk);
        out_ready = 1'b0;
        @(posedge clk); @(negedge clk);
        in_valid = 1'b0;
        #2 reset = 1'b1;
        #1;
        n_total++;
        if (out_valid !== 1'b0 || out_addr !== 2'd0 || full !== 1'b0 || err !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_async: valid=%b addr=%0d full=%b err=%b want 0 0 0 0",
                     out_valid, out_addr, full, err);
        end
        @(negedge clk);
        reset = 1'b0;
        #1;
        n_total++;
        if (in_ready !== 1'b1) begin
            n_bad++;
            $display("FAIL reset_ready: in_ready=%b want 1", in_ready);
        end
    endtask

    task automatic test_rtype_j();
        do_reset();
        out_ready = 1'b1;
        drive(3'd0, 5'd1, 5'd2, 5'd3, 6'h20, 0, 0);
        @(posedge clk); @(negedge clk);
        drive(3'd5, 0, 0, 0, 0, 0, 26'h100);
        #1;
        n_total++;
        if (out_valid !== 1'b1 || out_instr !== 32'h00221820 || out_addr !== 2'd0) begin
            n_bad++;
            $display("FAIL rtype: valid=%b instr=%h addr=%0d want 1 00221820 0",
                     out_valid, out_instr, out_addr);
        end
        @(posedge clk); @(negedge clk);
        in_valid = 1'b0;
        #1;
        n_total++;
        if (out_valid !== 1'b1 || out_instr !== 32'h08000100 || out_addr !== 2'd1) begin
            n_bad++;
            $display("FAIL jump: valid=%b instr=%h addr=%0d want 1 08000100 1",
                     out_valid, out_instr, out_addr);
        end
    endtask

    task automatic test_stall();
        do_reset();
        drive(3'd1, 5'd0, 5'd8, 5'd0, 0, 32'd4, 0);
        @(posedge clk); @(negedge clk);
        drive(3'd4, 5'd1, 5'd1, 5'd0, 0, 32'd7, 0);
        for (int i = 0; i < 3; i++) begin
            #1;
            n_total++;
            if (out_valid !== 1'b1 || out_instr !== 32'h8C080004 || out_addr !== 2'd0 ||
                in_ready !== 1'b0) begin
                n_bad++;
                $display("FAIL stall_hold[%0d]: valid=%b instr=%h addr=%0d rdy=%b want 1 8c080004 0 0",
                         i, out_valid, out_instr, out_addr, in_ready);
            end
            @(posedge clk); @(negedge clk);
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); @(negedge clk);
        #1;
        n_total++;
        if (out_valid !== 1'b0 || out_addr !== 2'd1) begin
            n_bad++;
            $display("FAIL stall_consume: valid=%b addr=%0d want 0 1", out_valid, out_addr);
        end
    endtask

    task automatic test_li();
        do_reset();
        out_ready = 1'b1;
        drive(3'd6, 0, 5'd9, 0, 0, 32'hFFFF8000, 0);
        @(posedge clk); @(negedge clk);
        drive(3'd6, 0, 5'd9, 0, 0, 32'h12345678, 0);
        #1;
        n_total++;
        if (out_valid !== 1'b1 || out_instr !== 32'h20098000 || out_addr !== 2'd0) begin
            n_bad++;
            $display("FAIL li_short: valid=%b instr=%h addr=%0d want 1 20098000 0",
                     out_valid, out_instr, out_addr);
        end
        @(posedge clk); @(negedge clk);
        in_valid = 1'b0;
        #1;
`ifdef MIPS_ENC_LUI_EN
        n_total++;
        if (out_valid !== 1'b1 || out_instr !== 32'h3C091234 || out_addr !== 2'd1 ||
            in_ready !== 1'b0) begin
            n_bad++;
            $display("FAIL li_lui: valid=%b instr=%h addr=%0d rdy=%b want 1 3c091234 1 0",
                     out_valid, out_instr, out_addr, in_ready);
        end
        @(posedge clk); @(negedge clk);
        #1;
        n_total++;
        if (out_valid !== 1'b1 || out_instr !== 32'h35295678 || out_addr !== 2'd2) begin
            n_bad++;
            $display("FAIL li_ori: valid=%b instr=%h addr=%0d want 1 35295678 2",
                     out_valid, out_instr, out_addr);
        end
        @(posedge clk); @(negedge clk);
        // Only slot 3 remains: a two-word LI must be dropped.
        drive(3'd6, 0, 5'd9, 0, 0, 32'h12345678, 0);
        @(posedge clk); @(negedge clk);
        in_valid = 1'b0;
        #1;
`endif
        n_total++;
        if (err !== 1'b1 || out_valid !== 1'b0) begin
            n_bad++;
            $display("FAIL li_drop: err=%b valid=%b want 1 0", err, out_valid);
        end
        n_total++;
`ifdef MIPS_ENC_LUI_EN
        if (out_addr !== 2'd3) begin
            n_bad++;
            $display("FAIL li_drop_addr: addr=%0d want 3", out_addr);
        end
`else
        if (out_addr !== 2'd1) begin
            n_bad++;
            $display("FAIL li_drop_addr: addr=%0d want 1", out_addr);
        end
`endif
        @(posedge clk); @(negedge clk);
        #1;
        n_total++;
        if (err !== 1'b0) begin
            n_bad++;
            $display("FAIL err_pulse: err=%b want 0", err);
        end
    endtask

    task automatic test_full();
        do_reset();
        out_ready = 1'b1;
        drive(3'd7, 0, 0, 0, 0, 0, 0);
        @(posedge clk);
        for (int i = 0; i < CAP; i++) begin
            @(negedge clk);
            in_valid = (i < CAP - 1);
            #1;
            n_total++;
            if (out_valid !== 1'b1 || out_instr !== 32'h0 || out_addr !== 2'(i) || full !== 1'b0) begin
                n_bad++;
                $display("FAIL nop_word[%0d]: valid=%b instr=%h addr=%0d full=%b want 1 0 %0d 0",
                         i, out_valid, out_instr, out_addr, full, i);
            end
            @(posedge clk);
        end
        @(negedge clk);
        in_valid = 1'b1;
        #1;
        n_total++;
        if (full !== 1'b1 || in_ready !== 1'b0 || out_addr !== 2'd0 || out_valid !== 1'b0) begin
            n_bad++;
            $display("FAIL full_set: full=%b rdy=%b addr=%0d valid=%b want 1 0 0 0",
                     full, in_ready, out_addr, out_valid);
        end
        @(posedge clk); @(negedge clk);
        clear = 1'b1;
        #1;
        n_total++;
        if (out_valid !== 1'b0 || in_ready !== 1'b0) begin
            n_bad++;
            $display("FAIL full_blocks: valid=%b rdy=%b want 0 0", out_valid, in_ready);
        end
        @(posedge clk); @(negedge clk);
        clear = 1'b0;
        in_valid = 1'b0;
        #1;
        n_total++;
        if (full !== 1'b0 || in_ready !== 1'b1) begin
            n_bad++;
            $display("FAIL full_clear: full=%b rdy=%b want 0 1", full, in_ready);
        end
    endtask

    task automatic test_clear();
        do_reset();
        out_ready = 1'b1;
        drive(3'd4, 5'd2, 5'd3, 0, 0, 32'd5, 0);
        @(posedge clk); @(negedge clk);
        drive(3'd4, 5'd4, 5'd5, 0, 0, 32'd6, 0);
        @(posedge clk); @(negedge clk);
        in_valid = 1'b0;
        out_ready = 1'b0;
        @(posedge clk); @(negedge clk);
        clear = 1'b1;
        out_ready = 1'b1;
        drive(3'd0, 5'd1, 5'd1, 5'd1, 6'h20, 0, 0);
        #1;
        n_total++;
        if (in_ready !== 1'b0) begin
            n_bad++;
            $display("FAIL clear_ready: in_ready=%b want 0", in_ready);
        end
        @(posedge clk); @(negedge clk);
        clear = 1'b0;
        in_valid = 1'b0;
        #1;
        n_total++;
        if (out_valid !== 1'b0 || out_addr !== 2'd0 || err !== 1'b0) begin
            n_bad++;
            $display("FAIL clear_state: valid=%b addr=%0d err=%b want 0 0 0",
                     out_valid, out_addr, err);
        end
    endtask

    task automatic test_random();
        int          n;
        logic [31:0] w0, w1, r;
        bit          exp_ready, consume, accept;
        do_reset();
        m_q.delete();
        m_addr = 0; m_full = 0; m_err = 0;
        for (int cyc = 0; cyc < 600; cyc++) begin
            clear     = m_full ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 39) == 0);
            in_valid  = ($urandom_range(0, 9) < 7);
            out_ready = ($urandom_range(0, 9) < 6);
            in_kind   = 3'($urandom_range(0, 7));
            in_rs     = 5'($urandom); in_rt = 5'($urandom); in_rd = 5'($urandom);
            in_funct  = 6'($urandom);
            in_target = 26'($urandom);
            r = $urandom;
            case ($urandom_range(0, 2))
                0: in_imm = {{16{r[15]}}, r[15:0]};
                1: in_imm = r;
                default: in_imm = (r[0]) ? {16'h0000, r[1], 15'h7fff} : {16'hffff, r[1], 15'h0};
            endcase
            exp_ready = !m_full && !clear && (m_q.size() == 0 || (m_q.size() == 1 && out_ready));
            #1;
            n_total++;
            if (out_valid !== (m_q.size() > 0) || out_addr !== 2'(m_addr) || full !== m_full ||
                err !== m_err || in_ready !== exp_ready ||
                (m_q.size() > 0 && out_instr !== m_q[0])) begin
                n_bad++;
                $display("FAIL random[%0d]: valid=%b addr=%0d full=%b err=%b rdy=%b instr=%h want %b %0d %b %b %b %h",
                         cyc, out_valid, out_addr, full, err, in_ready, out_instr,
                         (m_q.size() > 0), m_addr, m_full, m_err, exp_ready,
                         (m_q.size() > 0) ? m_q[0] : 32'h0);
            end
            @(posedge clk);
            if (clear) begin
                m_q.delete();
                m_addr = 0; m_full = 0; m_err = 0;
            end else begin
                consume = (m_q.size() > 0) && out_ready;
                accept  = in_valid && exp_ready;
                m_err   = 0;
                if (consume) begin
                    void'(m_q.pop_front());
                    if (m_addr == CAP - 1) m_full = 1;
                    m_addr = (m_addr + 1) % CAP;
                end
                if (accept) begin
                    model_encode(n, w0, w1);
                    if (n == 0 || (n == 2 && m_addr == CAP - 1)) begin
                        m_err = 1;
                    end else begin
                        m_q.push_back(w0);
                        if (n == 2) m_q.push_back(w1);
                    end
                end
            end
            @(negedge clk);
        end
        clear = 1'b0;
        in_valid = 1'b0;
    endtask

    initial begin
        test_reset();
        test_rtype_j();
        test_stall();
        test_li();
        test_full();
        test_clear();
        test_random();
        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
